// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ITER     = 32;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Values match the RV32M funct3 field
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface mul_div_unit_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            Start;
  logic [2:0]      Op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [4:0]      RdIn;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic [4:0]      RdOut;
  logic            RFWr;

  modport master (
    output Start, Op, A, B, RdIn,
    input  Busy, Done, Result, RdOut, RFWr
  );

  modport slave (
    input  Start, Op, A, B, RdIn,
    output Busy, Done, Result, RdOut, RFWr
  );

endinterface

// File: rtl/muldiv_fixup.sv
// Combinational sign fix-up: negates the magnitude result when required and
// selects the low/high product word, quotient or remainder.
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  op_e             op,
  input  logic            neg,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;

  assign prod_s = {hi, lo};

  // Select and sign-correct the architectural result
  always_comb begin
    prod_fix_s = prod_s;
    result     = lo;
    if (neg) begin
      prod_fix_s = -prod_s;
    end else begin
      prod_fix_s = prod_s;
    end
    case (op)
      OP_MUL:                       result = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = neg ? -lo : lo;
      OP_REM, OP_REMU:              result = neg ? -hi : hi;
      default:                      result = lo;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide unit, 34-cycle fixed latency.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (div by zero, overflow, mul by 0) go straight to FIN.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  mul_div_unit_if.slave bus
);

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_e          state_r, state_nxt_s;
  op_e             op_r, op_in_s, fx_op_s;
  logic [4:0]      cnt_r, rd_r, rdout_r;
  logic [XLEN-1:0] hi_r, lo_r, opnd_r, result_r;
  logic            neg_r, busy_r, done_r, rfwr_r;

  logic            op_div_s, sgn_a_op_s, sgn_b_op_s, sa_s, sb_s, bz_s, neg_s, early_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s, pre_lo_s, pre_opnd_s, early_hi_s, early_lo_s;
  logic [XLEN:0]   add_s, rem_t_s;
  logic            ge_s, fx_neg_s;
  logic [XLEN-1:0] diff_s, step_hi_s, step_lo_s, fx_hi_s, fx_lo_s, fx_res_s;

  assign op_in_s = op_e'(bus.Op);
  assign op_div_s = bus.Op[2];

  // Operand signedness per opcode and the sign the final result must carry
  always_comb begin
    sgn_a_op_s = 1'b0;
    sgn_b_op_s = 1'b0;
    case (op_in_s)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn_a_op_s = 1'b1;
        sgn_b_op_s = 1'b1;
      end
      OP_MULHSU: begin
        sgn_a_op_s = 1'b1;
        sgn_b_op_s = 1'b0;
      end
      default: begin
        sgn_a_op_s = 1'b0;
        sgn_b_op_s = 1'b0;
      end
    endcase
    sa_s = bus.A[XLEN-1] & sgn_a_op_s;
    sb_s = bus.B[XLEN-1] & sgn_b_op_s;
    // Division by zero keeps the all-ones quotient unsigned-looking
    case (op_in_s)
      OP_MUL, OP_MULH: neg_s = sa_s ^ sb_s;
      OP_MULHSU:       neg_s = sa_s;
      OP_DIV:          neg_s = (sa_s ^ sb_s) & ~bz_s;
      OP_REM:          neg_s = sa_s;
      default:         neg_s = 1'b0;
    endcase
  end

  assign abs_a_s    = sa_s ? -bus.A : bus.A;
  assign abs_b_s    = sb_s ? -bus.B : bus.B;
  assign bz_s       = (bus.B == {XLEN{1'b0}});
  assign pre_lo_s   = op_div_s ? abs_a_s : abs_b_s;
  assign pre_opnd_s = op_div_s ? abs_b_s : abs_a_s;

`ifdef MULDIV_EARLY_OUT_EN
  logic ovf_s;
  assign ovf_s      = op_div_s & sgn_a_op_s & (bus.A == INT_MIN) & (bus.B == DIV0_Q);
  assign early_s    = op_div_s ? (bz_s | ovf_s) : ((bus.A == {XLEN{1'b0}}) | bz_s);
  assign early_hi_s = (op_div_s & bz_s) ? abs_a_s : {XLEN{1'b0}};
  assign early_lo_s = !op_div_s ? {XLEN{1'b0}} : (bz_s ? DIV0_Q : INT_MIN);
`else
  assign early_s    = 1'b0;
  assign early_hi_s = {XLEN{1'b0}};
  assign early_lo_s = {XLEN{1'b0}};
`endif

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    add_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    rem_t_s = {hi_r, lo_r[XLEN-1]};
    ge_s    = (rem_t_s >= {1'b0, opnd_r});
    diff_s  = rem_t_s[XLEN-1:0] - opnd_r;
    if (op_r[2]) begin
      step_hi_s = ge_s ? diff_s : rem_t_s[XLEN-1:0];
      step_lo_s = {lo_r[XLEN-2:0], ge_s};
    end else begin
      step_hi_s = add_s[XLEN:1];
      step_lo_s = {add_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Fix-up sees the early-out values in IDLE and the final step otherwise
  always_comb begin
    fx_op_s  = op_r;
    fx_neg_s = neg_r;
    fx_hi_s  = step_hi_s;
    fx_lo_s  = step_lo_s;
    if (state_r == IDLE) begin
      fx_op_s  = op_in_s;
      fx_neg_s = neg_s;
      fx_hi_s  = early_hi_s;
      fx_lo_s  = early_lo_s;
    end else begin
      fx_op_s  = op_r;
      fx_neg_s = neg_r;
      fx_hi_s  = step_hi_s;
      fx_lo_s  = step_lo_s;
    end
  end

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .op     (fx_op_s),
    .neg    (fx_neg_s),
    .hi     (fx_hi_s),
    .lo     (fx_lo_s),
    .result (fx_res_s)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          state_nxt_s = early_s ? FIN : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath, counter and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      op_r     <= OP_MUL;
      neg_r    <= 1'b0;
      rd_r     <= 5'd0;
      cnt_r    <= 5'd0;
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      opnd_r   <= {XLEN{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rfwr_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
      rdout_r  <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Start) begin
            op_r   <= op_in_s;
            neg_r  <= neg_s;
            rd_r   <= bus.RdIn;
            cnt_r  <= 5'd0;
            busy_r <= 1'b1;
            hi_r   <= {XLEN{1'b0}};
            lo_r   <= pre_lo_s;
            opnd_r <= pre_opnd_s;
            if (early_s) begin
              result_r <= fx_res_s;
              rdout_r  <= bus.RdIn;
              done_r   <= 1'b1;
              rfwr_r   <= (bus.RdIn != 5'd0);
            end
          end
        end
        CALC: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == LAST_CNT) begin
            result_r <= fx_res_s;
            rdout_r  <= rd_r;
            done_r   <= 1'b1;
            rfwr_r   <= (rd_r != 5'd0);
          end
        end
        default: begin
          done_r <= 1'b0;
          rfwr_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.RFWr   = rfwr_r;
  assign bus.Result = result_r;
  assign bus.RdOut  = rdout_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an arithmetic reference model and a per-cycle comparator.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  localparam int BIG = 1000000000;

  logic CLK = 1'b0;
  logic RST_N;

  mul_div_unit_if bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Expected architectural state: previous and pending result/rd, and the cycle window of the op
  logic [31:0] prev_res = 32'd0, exp_res = 32'd0;
  logic [4:0]  prev_rd = 5'd0, exp_rd = 5'd0;
  int          acc_cyc = BIG, done_cyc = BIG;
  logic        exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      exp_done = (cyc == done_cyc);
      check("done", {31'd0, bus.Done}, {31'd0, exp_done});
      check("rfwr", {31'd0, bus.RFWr}, {31'd0, exp_done && (exp_rd != 5'd0)});
      check("busy", {31'd0, bus.Busy}, {31'd0, (cyc >= acc_cyc) && (cyc <= done_cyc)});
      check("result", bus.Result, (cyc >= done_cyc) ? exp_res : prev_res);
      check("rdout", {27'd0, bus.RdOut}, {27'd0, (cyc >= done_cyc) ? exp_rd : prev_rd});
    end
  end

  task automatic model_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int lat);
    int c;
    c = cyc;
    if (c >= done_cyc) begin
      prev_res = exp_res;
      prev_rd  = exp_rd;
    end
    exp_res  = ref_model(op, a, b);
    exp_rd   = rd;
    acc_cyc  = c + 1;
    done_cyc = c + lat;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.RdIn  = rd;
    bus.Start = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit, input bit early,
                        input bit inject, input bit chk_res0);
    int got, lat;
    logic [31:0] seen;
`ifdef MULDIV_EARLY_OUT_EN
    lat = early ? 1 : 33;
`else
    lat = 33;
`endif
    got  = 0;
    seen = 32'd0;
    check("model_pin", ref_model(op, a, b), lit);
    model_start(op, a, b, rd, lat);
    @(negedge CLK);
    check("idle_busy", {31'd0, bus.Busy}, 32'd0);
    if (chk_res0) check("post_reset_result", bus.Result, 32'd0);
    @(posedge CLK); #1;
    bus.A    = ~a;
    bus.B    = ~b;
    bus.RdIn = ~rd;
    for (int i = 1; i <= 40; i++) begin
      if (inject && i == 10) begin
        bus.Start = 1'b1;
        bus.Op    = OP_MUL;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge CLK);
      if (bus.Done) begin
        got  = i;
        seen = bus.Result;
        break;
      end
      @(posedge CLK); #1;
    end
    bus.Start = 1'b0;
    check("latency", got, lat);
    check("result_lit", seen, lit);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn;
    RST_N     = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.RdIn  = 5'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk_en = 1'b1;
    @(negedge CLK);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_rfwr", {31'd0, bus.RFWr}, 32'd0);
    check("rst_result", bus.Result, 32'd0);
    check("rst_rdout", {27'd0, bus.RdOut}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op(OP_DIV,    32'd7,          32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op(OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd8,  32'd1,         1'b0, 1'b0, 1'b0);
    run_op(OP_REMU,   32'd17,         32'd5,         5'd10, 32'd2,         1'b0, 1'b0, 1'b0);
    run_op(OP_DIVU,   32'd10,         32'd0,         5'd4,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'd0,         1'b1, 1'b0, 1'b0);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_op(OP_DIV,    32'hFFFF_FFFB,  32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(OP_REM,    32'hFFFF_FFFB,  32'd0,         5'd14, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0);
    run_op(OP_MUL,    32'd0,          32'h1234_5678, 5'd15, 32'd0,         1'b1, 1'b0, 1'b0);
    run_op(OP_DIV,    32'd100,        32'd3,         5'd0,  32'd33,        1'b0, 1'b1, 1'b0);

    // Reset in cycle 15 of a divide must abort it silently
    dn = 0;
    model_start(OP_DIV, 32'd1000, 32'd7, 5'd9, 33);
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge CLK);
      if (bus.Done) dn++;
      @(posedge CLK); #1;
    end
    RST_N = 1'b0;
    @(negedge CLK);
    if (bus.Done) dn++;
    @(posedge CLK); #1;
    prev_res = 32'd0;
    exp_res  = 32'd0;
    prev_rd  = 5'd0;
    exp_rd   = 5'd0;
    acc_cyc  = BIG;
    done_cyc = BIG;
    RST_N    = 1'b1;
    check("abort_no_done", dn, 32'd0);
    run_op(OP_DIVU, 32'd1000, 32'd7, 5'd9, 32'd142, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand/result width (only 32 supported).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port RST_N, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1, a request to begin an operation.
REQ-005 The block SHALL have port Op, input, 3, RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-006 The block SHALL have ports A and B, input, XLEN, operands taken from register-file read ports rs1/rs2.
REQ-007 The block SHALL have port RdIn, input, 5, the destination register index.
REQ-008 The block SHALL have port Busy, output, 1, high while an operation is in flight.
REQ-009 The block SHALL have port Done, output, 1, a one-cycle pulse when Result is valid.
REQ-010 The block SHALL have ports Result (output, XLEN, write-back data), RdOut (output, 5, latched RdIn) and RFWr (output, 1, equal to Done AND RdOut!=0), for the register-file write port.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and FIN.
REQ-012 In IDLE, Start=1 SHALL latch Op, A, B and RdIn, preload the operands (absolute values for signed ops), clear the iteration counter, and move to CALC; Busy rises the next cycle.
REQ-013 CALC SHALL run exactly 32 cycles of a radix-2 step (shift-add for MUL*, restoring shift-subtract for DIV*/REM*); the counter reaching 31 moves to FIN.
REQ-014 FIN SHALL apply the sign fix-up, drive Result, pulse Done and RFWr for one cycle, and return to IDLE.
REQ-015 Latency SHALL be 34 cycles (Start sampled at edge 0, Done high in cycle 33), and the block accepts the next Start in the cycle after Done.
REQ-016 Start while Busy=1 or Done=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-017 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
REQ-018 Division by zero SHALL give quotient 0xFFFFFFFF (DIV and DIVU) and remainder equal to A (REM and REMU).
REQ-019 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0.
REQ-020 A signed remainder SHALL take the sign of the dividend, and a signed quotient SHALL be truncated toward zero.
REQ-021 Result and RdOut SHALL hold their last value until the next FIN; Done and RFWr SHALL be 0 outside FIN.

Reset
REQ-022 RST_N=0 at a rising edge SHALL force IDLE and clear Busy, Done, RFWr, Result, RdOut, the counter and all datapath registers to 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no Done or RFWr pulse, and Start is honoured in the first cycle with RST_N=1.

Configuration
REQ-024 With macro MULDIV_EARLY_OUT_EN defined, division by zero, signed overflow, and MUL* with either operand 0 SHALL skip CALC and go IDLE->FIN, giving Done in cycle 1 with the REQ-017/018/019 results.
REQ-025 Without MULDIV_EARLY_OUT_EN, all operations SHALL take the fixed 34-cycle latency of REQ-015.

Structure
REQ-026 Package muldiv_pkg SHALL hold the Op encoding enum (funct3 values), the FSM state enum, XLEN_DEF=32, ITER=32 and the constants DIV0_Q=0xFFFFFFFF and INT_MIN=0x80000000.
REQ-027 The sign fix-up (result negation and hi/lo select) SHALL be a combinational sub-module muldiv_fixup instantiated once.

Verification
REQ-028 The bench SHALL check MUL, A=7, B=0xFFFFFFFD (-3), RdIn=5: Done in cycle 33, Result=0xFFFFFFEB, RdOut=5, RFWr=1.
REQ-029 The bench SHALL check MULHU, A=B=0xFFFFFFFF, giving Result=0xFFFFFFFE; and MULH with the same operands, giving Result=0.
REQ-030 The bench SHALL check DIV, A=-7, B=2, giving Result=0xFFFFFFFD (-3); and REM with the same operands, giving Result=0xFFFFFFFF (-1).
REQ-031 The bench SHALL check DIVU, A=10, B=0, giving Result=0xFFFFFFFF; REM, A=0x80000000, B=-1, giving Result=0; early-out builds give Done in cycle 1.
REQ-032 The bench SHALL check DIV, A=100, B=3, RdIn=0: Result=33, Done=1, RFWr=0; and a Start pulse at cycle 10 is ignored.
REQ-033 The bench SHALL check that RST_N=0 at cycle 15 of a DIV gives Busy=0 and Result=0 next cycle with no Done pulse, and that a new Start then completes normally.
